// File: rtl/decode_buffer_if.sv
// decode_buffer_if: fetch-side, backend-side and control signals of the decode buffer
interface decode_buffer_if #(parameter int DEPTH = 4, parameter int XLEN = 32);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic out_illegal;
  logic out_regwrite;
  logic out_is_mem;
  logic out_is_cflow;
  logic out_serialize;
  logic serialize_done;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready, serialize_done,
    input in_ready, out_valid, out_instr, out_pc, out_illegal, out_regwrite,
    out_is_mem, out_is_cflow, out_serialize, count
  );
  modport slave (
    input flush, in_valid, in_instr, in_pc, out_ready, serialize_done,
    output in_ready, out_valid, out_instr, out_pc, out_illegal, out_regwrite,
    out_is_mem, out_is_cflow, out_serialize, count
  );
endinterface

// File: rtl/decode_buffer.sv
// decode_buffer: predecoding instruction FIFO that stalls after serializing instructions
module decode_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter bit ENABLE_M = 1,
  parameter bit ENABLE_ZICSR = 1
) (
  input logic clk,
  input logic rst,
  decode_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011,
    STORE = 7'b0100011, LUI = 7'b0110111, AUIPC = 7'b0010111, BRANCH = 7'b1100011,
    JAL = 7'b1101111, JALR = 7'b1100111, MISC_MEM = 7'b0001111, SYSTEM = 7'b1110011;
  typedef enum logic {RUN, WAIT} state_t;
  state_t state, state_n;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [31:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [4:0] flags_q [DEPTH];
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [11:0] imm;
  logic is_sys, csr, illegal, regwrite, is_mem, is_cflow, serialize, enq, deq;
  assign op = bus.in_instr[6:0];
  assign f3 = bus.in_instr[14:12];
  assign f7 = bus.in_instr[31:25];
  assign imm = bus.in_instr[31:20];
  assign is_sys = op == SYSTEM;
  assign csr = is_sys && f3 != 3'b000;
  assign illegal = bus.in_instr[1:0] != 2'b11
    || !(op inside {OP, OP_IMM, LOAD, STORE, LUI, AUIPC, BRANCH, JAL, JALR, MISC_MEM, SYSTEM})
    || (op == OP && !(f7 == 7'h00 || f7 == 7'h20 || (ENABLE_M && f7 == 7'h01)))
    || (is_sys && f3 == 3'b000 && !(imm inside {12'h000, 12'h001, 12'h302, 12'h105}))
    || (csr && !ENABLE_ZICSR);
  assign regwrite = !illegal && ((op inside {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR}) || csr);
  assign is_mem = !illegal && (op inside {LOAD, STORE});
  assign is_cflow = !illegal && (op inside {BRANCH, JAL, JALR});
  // WFI is the only legal SYSTEM funct3=0 instruction that does not serialize
  assign serialize = illegal || (op == MISC_MEM && f3 == 3'b001) || csr
    || (is_sys && f3 == 3'b000 && imm != 12'h105);
  assign enq = bus.in_valid && bus.in_ready && !bus.flush;
  assign deq = bus.out_valid && bus.out_ready && !bus.flush;
  assign bus.in_ready = count < (AW+1)'(DEPTH);
  assign bus.out_valid = count != '0 && state == RUN;
  assign bus.count = count;
  assign bus.out_instr = instr_q[rptr];
  assign bus.out_pc = pc_q[rptr];
  assign {bus.out_illegal, bus.out_regwrite, bus.out_is_mem, bus.out_is_cflow, bus.out_serialize} = flags_q[rptr];
  always_comb begin
    state_n = bus.flush ? RUN
      : (state == RUN) ? ((deq && bus.out_serialize) ? WAIT : RUN)
      : (bus.serialize_done ? RUN : WAIT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (bus.flush) begin
      state <= RUN;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      wptr <= wptr + AW'(enq);
      rptr <= rptr + AW'(deq);
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wptr] <= bus.in_instr;
      pc_q[wptr] <= bus.in_pc;
      flags_q[wptr] <= {illegal, regwrite, is_mem, is_cflow, serialize};
    end
  end
endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: directed and randomized checks of decode_buffer against a queue model
module tb_decode_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] ADD = 32'h002081B3, MUL = 32'h022081B3, ECALL = 32'h00000073,
    CSRRW = 32'h34011073, WFI = 32'h10500073;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mq_i [$];
  logic [31:0] mq_p [$];
  bit mwait = 0;
  decode_buffer_if #(.DEPTH(DEPTH), .XLEN(32)) bus ();
  decode_buffer_if #(.DEPTH(DEPTH), .XLEN(32)) bus2 ();
  decode_buffer #(.DEPTH(DEPTH), .XLEN(32), .ENABLE_M(1), .ENABLE_ZICSR(1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  decode_buffer #(.DEPTH(DEPTH), .XLEN(32), .ENABLE_M(0), .ENABLE_ZICSR(0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;

  // {illegal, regwrite, is_mem, is_cflow, serialize} from the ISA decoding rules
  function automatic logic [4:0] model_dec(input logic [31:0] i, input bit m, input bit z);
    logic [6:0] f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    logic [11:0] imm = i[31:20];
    bit ill = 0, rw = 0, mem = 0, cf = 0, ser = 0;
    case (i[6:0])
      7'h33: begin ill = !(f7 == 0 || f7 == 7'h20 || (m && f7 == 1)); rw = 1; end
      7'h13, 7'h37, 7'h17: rw = 1;
      7'h03: begin rw = 1; mem = 1; end
      7'h23: mem = 1;
      7'h63: cf = 1;
      7'h6F, 7'h67: begin rw = 1; cf = 1; end
      7'h0F: ser = f3 == 1;
      7'h73:
        if (f3 != 0) begin ill = !z; rw = 1; ser = 1; end
        else begin
          ill = !(imm == 0 || imm == 1 || imm == 12'h302 || imm == 12'h105);
          ser = imm != 12'h105;
        end
      default: ill = 1;
    endcase
    return ill ? 5'b10001 : {1'b0, rw, mem, cf, ser};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 5);
    int j = $urandom_range(0, 4);
    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73};
    logic [6:0] f7 = j == 0 ? 7'h00 : j == 1 ? 7'h20 : j == 2 ? 7'h01 : r[31:25];
    logic [11:0] imm = j == 0 ? 12'h000 : j == 1 ? 12'h001 : j == 2 ? 12'h302 : j == 3 ? 12'h105 : r[31:20];
    logic [2:0] f3 = 3'($urandom_range(1, 7));
    if (k == 0) return r;
    if (k == 1) return {f7, r[24:7], 7'h33};
    if (k == 2) return {imm, r[19:15], 3'b000, r[11:7], 7'h73};
    if (k == 3) return {r[31:15], f3, r[11:7], 7'h73};
    return {r[31:7], ops[$urandom_range(0, 10)]};
  endfunction

  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit sd, input bit fl);
    bit e, d;
    logic [4:0] hf;
    bus.in_valid = iv; bus.in_instr = ins; bus.in_pc = pc;
    bus.out_ready = ordy; bus.serialize_done = sd; bus.flush = fl;
    e = iv && mq_i.size() < DEPTH && !fl;
    d = ordy && mq_i.size() != 0 && !mwait && !fl;
    @(posedge clk);
    if (fl) begin
      mq_i.delete(); mq_p.delete(); mwait = 0;
    end else begin
      if (d) begin
        hf = model_dec(mq_i[0], 1, 1);
        mwait = hf[0];
        void'(mq_i.pop_front()); void'(mq_p.pop_front());
      end else if (mwait && sd) mwait = 0;
      if (e) begin mq_i.push_back(ins); mq_p.push_back(pc); end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.count, bus.out_valid, bus.in_ready} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_state: got count/valid/ready %b expected 00001", {bus.count, bus.out_valid, bus.in_ready});
    end
    rst = 0;
    mq_i.delete(); mq_p.delete(); mwait = 0;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_add();
    cycle(1, ADD, 32'h100, 0, 0, 0);
    n_chk++;
    if ({bus.out_valid, bus.out_regwrite, bus.out_illegal, bus.out_serialize, bus.count} !== {4'b1100, 3'd1}) begin
      n_fail++; $display("FAIL add_enqueue: got v/rw/ill/ser/count %b expected 1100001",
        {bus.out_valid, bus.out_regwrite, bus.out_illegal, bus.out_serialize, bus.count});
    end
    n_chk++;
    if ({bus.out_instr, bus.out_pc} !== {ADD, 32'h100}) begin
      n_fail++; $display("FAIL add_head: got %h/%h expected %h/00000100", bus.out_instr, bus.out_pc, ADD);
    end
    cycle(0, 0, 0, 1, 0, 0);
    n_chk++;
    if ({bus.out_valid, bus.count} !== 4'b0000) begin
      n_fail++; $display("FAIL add_dequeue: got valid/count %b expected 0000", {bus.out_valid, bus.count});
    end
  endtask

  task automatic test_serialize();
    cycle(1, ECALL, 32'h200, 0, 0, 0);
    n_chk++;
    if ({bus.out_valid, bus.out_serialize, bus.out_regwrite} !== 3'b110) begin
      n_fail++; $display("FAIL ecall_head: got v/ser/rw %b expected 110", {bus.out_valid, bus.out_serialize, bus.out_regwrite});
    end
    cycle(1, ADD, 32'h204, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({bus.out_valid, bus.count} !== {1'b0, 3'd1}) begin
        n_fail++; $display("FAIL ecall_wait%0d: got valid/count %b expected 0001", i, {bus.out_valid, bus.count});
      end
      cycle(0, 0, 0, 1, 0, 0);
    end
    cycle(0, 0, 0, 1, 1, 0);
    n_chk++;
    if ({bus.out_valid, bus.out_instr, bus.out_pc} !== {1'b1, ADD, 32'h204}) begin
      n_fail++; $display("FAIL ecall_resume: got valid %b head %h/%h expected 1 %h/00000204", bus.out_valid, bus.out_instr, bus.out_pc, ADD);
    end
    cycle(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (bus.count !== 3'd0) begin n_fail++; $display("FAIL ecall_drain: got count %0d expected 0", bus.count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) cycle(1, {12'(i), 13'd0, 7'h13}, 32'(i * 4), 0, 0, 0);
    n_chk++;
    if ({bus.count, bus.in_ready} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full: got count/ready %b expected 1000", {bus.count, bus.in_ready});
    end
    cycle(1, 32'h7FF00093, 32'h50, 1, 0, 0);
    n_chk++;
    if (bus.count !== 3'd3) begin n_fail++; $display("FAIL full_deq_blocks_enq: got count %0d expected 3", bus.count); end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if ({bus.out_valid, bus.out_instr, bus.out_pc} !== {1'b1, 12'(i), 13'd0, 7'h13, 32'(i * 4)}) begin
        n_fail++; $display("FAIL drain_order%0d: got %b %h/%h expected 1 %h/%h", i, bus.out_valid, bus.out_instr, bus.out_pc,
          {12'(i), 13'd0, 7'h13}, 32'(i * 4));
      end
      cycle(0, 0, 0, 1, 0, 0);
    end
    n_chk++;
    if ({bus.count, bus.out_valid, bus.in_ready} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL drain_empty: got count/valid/ready %b expected 00001", {bus.count, bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1, ADD + 32'(i << 7), 32'(i), 0, 0, 0);
    n_chk++;
    if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_fill: got count %0d expected 3", bus.count); end
    cycle(1, 32'h00500093, 32'h99, 1, 0, 1);
    n_chk++;
    if ({bus.count, bus.out_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL flush_clear: got count/valid %b expected 0000", {bus.count, bus.out_valid});
    end
    cycle(1, ADD, 32'h300, 0, 0, 0);
    n_chk++;
    if ({bus.count, bus.out_instr, bus.out_pc} !== {3'd1, ADD, 32'h300}) begin
      n_fail++; $display("FAIL flush_after: got count %0d head %h/%h expected 1 %h/00000300", bus.count, bus.out_instr, bus.out_pc, ADD);
    end
    cycle(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_reset_wait();
    cycle(1, ECALL, 32'h400, 0, 0, 0);
    cycle(1, ADD, 32'h404, 0, 0, 0);
    cycle(1, ADD, 32'h408, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_chk++;
    if ({bus.count, bus.out_valid} !== {3'd2, 1'b0}) begin
      n_fail++; $display("FAIL wait_before_rst: got count/valid %b expected 0100", {bus.count, bus.out_valid});
    end
    rst = 1;
    #1;
    n_chk++;
    if ({bus.count, bus.out_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL async_rst: got count/valid %b expected 0000", {bus.count, bus.out_valid});
    end
    @(posedge clk);
    #1;
    rst = 0;
    mq_i.delete(); mq_p.delete(); mwait = 0;
    cycle(1, ADD, 32'h500, 0, 0, 0);
    n_chk++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_leaves_wait: got valid %b expected 1", bus.out_valid); end
    cycle(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_add_dequeue: got count %0d expected 0", bus.count); end
  endtask

  task automatic test_no_m();
    logic [31:0] ins [4] = '{MUL, CSRRW, ADD, WFI};
    logic [4:0] exp [4] = '{5'b10001, 5'b10001, 5'b01000, 5'b00000};
    logic [4:0] got;
    for (int i = 0; i < 4; i++) begin
      bus2.in_valid = 1; bus2.in_instr = ins[i]; bus2.in_pc = 32'(i);
      @(posedge clk);
      #1;
      bus2.in_valid = 0;
      got = {bus2.out_illegal, bus2.out_regwrite, bus2.out_is_mem, bus2.out_is_cflow, bus2.out_serialize};
      n_chk++;
      if (got !== exp[i] || got !== model_dec(ins[i], 0, 0) || bus2.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL no_m_flags %h: got flags %b valid %b expected %b valid 1", ins[i], got, bus2.out_valid, exp[i]);
      end
      bus2.flush = 1;
      @(posedge clk);
      #1;
      bus2.flush = 0;
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [4:0] hf;
    for (int c = 0; c < 600; c++) begin
      n_chk++;
      if ({bus.count, bus.in_ready, bus.out_valid} !== {3'(mq_i.size()), mq_i.size() < DEPTH, mq_i.size() != 0 && !mwait}) begin
        n_fail++; $display("FAIL rand_ctrl c%0d: got count/ready/valid %b expected %b", c, {bus.count, bus.in_ready, bus.out_valid},
          {3'(mq_i.size()), mq_i.size() < DEPTH, mq_i.size() != 0 && !mwait});
      end
      if (mq_i.size() != 0) begin
        hf = model_dec(mq_i[0], 1, 1);
        n_chk++;
        if ({bus.out_instr, bus.out_pc, bus.out_illegal, bus.out_regwrite, bus.out_is_mem, bus.out_is_cflow, bus.out_serialize}
            !== {mq_i[0], mq_p[0], hf}) begin
          n_fail++; $display("FAIL rand_head c%0d: got %h/%h/%b expected %h/%h/%b", c, bus.out_instr, bus.out_pc,
            {bus.out_illegal, bus.out_regwrite, bus.out_is_mem, bus.out_is_cflow, bus.out_serialize}, mq_i[0], mq_p[0], hf);
        end
      end
      ins = rand_instr();
      cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
    end
  endtask

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0; bus.serialize_done = 0;
    bus2.flush = 0; bus2.in_valid = 0; bus2.in_instr = 0; bus2.in_pc = 0; bus2.out_ready = 0; bus2.serialize_done = 0;
    test_reset();
    test_add();
    test_serialize();
    test_full();
    test_flush();
    test_reset_wait();
    test_no_m();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_buffer.md
DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries in buffer (power of 2, >=2).
REQ-002 SHALL have parameter XLEN, default 32, PC width.
REQ-003 SHALL have parameter ENABLE_M, default 1, funct7=0x01 on OP legal when 1.
REQ-004 SHALL have parameter ENABLE_ZICSR, default 1, SYSTEM with funct3!=0 legal when 1.
REQ-005 SHALL have one clock; reset is asynchronous and active-high (clk, rst).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 flush  input  1  discard all entries, synchronous.
REQ-009 in_valid  input  1  fetch offers instruction.
REQ-010 in_ready  output  1  buffer accepts this cycle.
REQ-011 in_instr  input  32  raw instruction.
REQ-012 in_pc  input  XLEN  instruction address.
REQ-013 out_valid  output  1  head entry presented.
REQ-014 out_ready  input  1  downstream consumes head.
REQ-015 out_instr / out_pc  output  32 / XLEN  head instruction and PC.
REQ-016 out_illegal  output  1  head is illegal.
REQ-017 out_regwrite  output  1  head writes rd (OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, CSR).
REQ-018 out_is_mem / out_is_cflow  output  1 / 1  LOAD|STORE; BRANCH|JAL|JALR.
REQ-019 out_serialize  output  1  head is FENCE.I, ECALL, EBREAK, MRET, any CSR op, or illegal.
REQ-020 serialize_done  input  1  backend finished serializing instruction.
REQ-021 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-022 SHALL predecode in_instr combinationally at enqueue; store instr, pc, illegal, regwrite, is_mem, is_cflow, serialize per entry.
REQ-023 SHALL flag illegal: instr[1:0]!=2'b11; opcode outside {OP, OP-IMM, LOAD, STORE, LUI, AUIPC, BRANCH, JAL, JALR, MISC-MEM, SYSTEM}; OP funct7 not in {0x00, 0x20, 0x01 if ENABLE_M}; SYSTEM funct3=0 with imm[11:0] not in {0x000, 0x001, 0x302, 0x105}; SYSTEM funct3!=0 when ENABLE_ZICSR=0.
REQ-024 Illegal entries SHALL have regwrite=0, is_mem=0, is_cflow=0, serialize=1.
REQ-025 WFI (imm 0x105) SHALL be legal, non-serializing, regwrite=0; FENCE (funct3=0) legal NOP.
REQ-026 Enqueue SHALL occur when in_valid && in_ready && !flush; in_ready = (count<DEPTH).
REQ-027 Dequeue SHALL occur when out_valid && out_ready && !flush.
REQ-028 Latency SHALL be 1 cycle: entry enqueued in cycle N appears at head no earlier than N+1; no empty bypass.
REQ-029 Simultaneous enqueue and dequeue SHALL leave count unchanged; full blocks enqueue even if dequeuing.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH; count SHALL track 0..DEPTH exactly.
REQ-031 FSM states RUN, WAIT; RUN->WAIT on dequeue with out_serialize=1; WAIT->RUN on serialize_done; serialize_done in RUN ignored.
REQ-032 out_valid SHALL equal (count!=0) && state==RUN; out_* data fields SHALL show head entry regardless.
REQ-033 Enqueue SHALL continue in WAIT while not full.
REQ-034 flush SHALL set count=0, pointers=0, state=RUN next cycle, dropping concurrent enqueue and dequeue; flush beats serialize_done.
REQ-035 Head output fields SHALL be stable while out_valid && !out_ready.

Reset
REQ-036 rst SHALL asynchronously set count=0, pointers=0, state=RUN, out_valid=0, in_ready=1 (after rst deassert).
REQ-037 Entry storage SHALL need no reset; out_instr/out_pc undefined when out_valid=0.
REQ-038 Reset mid-operation SHALL discard all entries and the WAIT state immediately.

Verification
REQ-039 Enqueue 0x002081B3 (ADD) at cycle 0 -> cycle 1 out_valid=1, out_regwrite=1, out_illegal=0, out_serialize=0, count=1.
REQ-040 ENABLE_M=0, enqueue 0x022081B3 (MUL) -> out_illegal=1, out_serialize=1, out_regwrite=0.
REQ-041 Enqueue ECALL 0x00000073 then ADD, out_ready=1 -> ECALL dequeued, out_valid=0 until serialize_done pulse, ADD presented next cycle.
REQ-042 DEPTH=4, in_valid=1, out_ready=0 for 5 cycles -> count=4, in_ready=0, fifth instruction not accepted; drain 4 in order, pointers wrap, count=0.
REQ-043 flush with in_valid=1 and count=3 -> next cycle count=0, out_valid=0, flushed-cycle instruction absent.
REQ-044 Assert rst while in WAIT with count=2 -> count=0, out_valid=0 immediately; after release, new ADD dequeues without serialize_done.
